sseg_display_driver: RTL and testbench
======================================

# sseg_display_driver

Four-digit multiplexed seven-segment display driver consuming the 16-bit `sseg_value` word produced by the motion-sensor state logic (`16'h1111` for MOTION, `16'h0000` for STABLE) and driving the board's common-anode display. It scans one digit at a time, inserts an anti-ghosting blank gap between digits, and latches the display word only at frame boundaries so a value never tears mid-frame.

## Interface
- `DIGIT_PERIOD_CYCLES`, default 100_000: clock cycles per digit slot (1 ms at 100 MHz; 4 ms frame). Legal range 2 or more.
- `BLANK_CYCLES`, default 1_000: cycles at the start of each slot with all anodes off. Legal range 0 to `DIGIT_PERIOD_CYCLES`-1. A value of 0 disables the gap.
- `clk`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: synchronous, active-high.
- `value`, input, 16: hex word to display. Digit 0 (rightmost) is `value[3:0]` and digit 3 is `value[15:12]`.
- `dp_in`, input, 4: decimal-point request per digit, active-high.
- `an`, output, 4: anode enables, active-low, registered.
- `seg`, output, 7: cathodes ordered {g,f,e,d,c,b,a}, active-low, registered.
- `dp`, output, 1: decimal-point cathode, active-low, registered.
- `frame_tick`, output, 1: single-cycle pulse, registered, marking the start of a new frame.

## Operation
- **Slot counter `cnt`:** counts 0 to `DIGIT_PERIOD_CYCLES`-1, then wraps to 0.
  - On wrap, digit index `idx` (2 bits) increments. It wraps from 3 to 0.
- **Frame latch:** on the edge where `cnt`=P-1 and `idx`=3:
  - `value_q` is loaded from `value` and `dp_q` from `dp_in`.
  - `frame_tick` is asserted for the following cycle.
  - Changes to `value` or `dp_in` at any other time are ignored until the next frame.
- **Active phase:** when `cnt` is at least `BLANK_CYCLES`:
  - `an` is one-cold at bit `idx`.
  - `seg` is the hex decode of nibble `idx` of `value_q`. Digits 0–F use the standard glyphs: 0 is 7'b1000000, 1 is 7'b1111001, F is 7'b0001110.
  - `dp` is the inverse of `dp_q[idx]`.
- **Blank phase:** when `cnt` is below `BLANK_CYCLES`, outputs are `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
- **States:** none beyond (`cnt`, `idx`). No input handshake; `value` is level-sampled.

## Timing
- **Reset values:** `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame_tick`=0, `cnt`=0, `idx`=0, `value_q`=0, `dp_q`=0.
- **Reset is synchronous:** outputs change on the first clock edge with `reset` high. Reset asserted mid-slot or mid-frame aborts the scan, and the next edge produces the reset values.
- **Output latency:** one register stage. `an`, `seg` and `dp` reflect the `cnt`/`idx`/`value_q` from the previous cycle.
- **After reset release:** digit 0 shows `value_q`=0 (a "0" glyph) until the first frame latch, P×4 cycles later.
- **First `frame_tick`:** occurs the cycle after `cnt`=P-1 with `idx`=3, i.e. 4P cycles after reset release.
- **Input change at the latch edge:** the value sampled is the value present at that edge.
- **`BLANK_CYCLES`=0:** anodes never all-off between digits. The transition from one digit to the next is a single-cycle switch.

## Configuration
- **`SSEG_LZ_BLANK_EN` defined:** leading-zero blanking is enabled.
  - Digits 3, 2 and 1 are forced blank (`an` bit high, `seg` all-ones) while they and every higher digit are zero.
  - Digit 0 is always shown.
  - Example: `value_q`=16'h0000 displays only the rightmost "0"; 16'h0100 displays "100".
  - A requested decimal point still lights on a blanked digit. The anode stays enabled for `dp` only.
- **Macro undefined:** all four digits are always shown, including leading zeros.

## Structure
- **Shared package `sseg_pkg`:**
  - Segment glyph constants `SEG_0` to `SEG_F` and `SEG_OFF`.
  - Anode constants `AN_OFF` and the one-cold codes.
  - The `MOTION`/`STABLE` display words 16'h1111 and 16'h0000.
- **Sub-module `sseg_hex_decode`:** combinational, 4-bit nibble in, 7-bit active-low segments out. It is instantiated once, on the selected nibble.

## Test plan
All scenarios use P=8 and B=2 unless noted.
- **Reset:** reset held 3 cycles → `an`=1111, `seg`=1111111, `dp`=1, `frame_tick`=0 every cycle. Release → digit 0 shows "0" (`seg`=1000000, `an`=1110) from cycle B+1.
- **Steady scan:** `value`=16'h1111 → after the first `frame_tick`, each slot shows 2 cycles of all-off then 6 cycles of `an`=1110/1101/1011/0111 with `seg`=1111001. `frame_tick` has period 32 cycles.
- **No tearing:** `value` switches 16'h0000→16'h1111 while `idx`=1 → digits 1–3 still show "0" for the rest of that frame. Every digit shows "1" only after the next `frame_tick`.
- **Hex and decimal point:** `value`=16'hA5C3, `dp_in`=4'b0100 → glyphs 3, C, 5, A on digits 0–3, with `dp`=0 only during digit 2's active phase.
- **Mid-scan reset:** `reset` pulsed for one cycle during digit 2's active phase → outputs return to the reset values the next cycle and the scan restarts at digit 0 with `value_q`=0.
- **Leading-zero blanking** (with `SSEG_LZ_BLANK_EN`), `value`=16'h0040 → digits 3 and 2 keep `an` high for the whole slot, digit 1 shows "4", digit 0 shows "0". Without the macro, all four digits are lit.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the seven-segment display path.
//   - Segment glyphs SEG_0..SEG_F and SEG_OFF, ordered {g,f,e,d,c,b,a},
//     active-low (common-anode display).
//   - Anode codes AN_OFF and one-cold AN_DIG0..AN_DIG3, active-low.
//   - Display words for the motion-sensor state logic (MOTION/STABLE).
package sseg_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  localparam logic [15:0] SSEG_MOTION = 16'h1111;
  localparam logic [15:0] SSEG_STABLE = 16'h0000;

  // One-cold anode code for a digit index.
  function automatic logic [3:0] an_onecold(input logic [1:0] idx);
    logic [3:0] code;
    code = AN_DIG0;
    case (idx)
      2'd0:    code = AN_DIG0;
      2'd1:    code = AN_DIG1;
      2'd2:    code = AN_DIG2;
      default: code = AN_DIG3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational hex nibble to seven-segment glyph.
//   nibble : 4-bit hex digit in
//   seg    : segments {g,f,e,d,c,b,a}, active-low
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/sseg_display_driver.sv
// sseg_display_driver: four-digit multiplexed common-anode seven-segment
// driver with anti-ghosting blank gap and frame-boundary input latch.
//   DIGIT_PERIOD_CYCLES : cycles per digit slot (>= 2)
//   BLANK_CYCLES        : all-off cycles at slot start (0 .. period-1)
//   clk, reset          : clock, synchronous active-high reset
//   value[15:0]         : hex word; digit 0 (rightmost) = value[3:0]
//   dp_in[3:0]          : decimal-point request per digit, active-high
//   an[3:0]             : anodes, active-low, registered
//   seg[6:0]            : cathodes {g,f,e,d,c,b,a}, active-low, registered
//   dp                  : decimal-point cathode, active-low, registered
//   frame_tick          : one-cycle pulse at the start of each frame
// Optional feature: define SSEG_LZ_BLANK_EN for leading-zero blanking.
module sseg_display_driver
  import sseg_pkg::*;
#(
  parameter int DIGIT_PERIOD_CYCLES = 100_000,
  parameter int BLANK_CYCLES        = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (DIGIT_PERIOD_CYCLES > 2) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   value_q;
  logic [3:0]    dp_q;

  logic          slot_end;
  logic          frame_end;
  logic          blank;
  logic          lz_blank;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign slot_end  = (cnt == CW'(DIGIT_PERIOD_CYCLES - 1));
  assign frame_end = slot_end && (idx == 2'd3);

  // A zero-length gap is resolved at elaboration so no always-false compare remains.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign blank = 1'b0;
    end else begin : g_gap
      assign blank = (cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  assign nibble = value_q[idx*4 +: 4];

  sseg_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (glyph)
  );

`ifdef SSEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero;
  // digit 0 is always shown.
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (value_q[15:12] == 4'h0);
      2'd2:    lz_blank = (value_q[15:8]  == 8'h00);
      2'd1:    lz_blank = (value_q[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!blank) begin
      dp_d = ~dp_q[idx];
      if (!lz_blank) begin
        an_d  = an_onecold(idx);
        seg_d = glyph;
      end else if (dp_q[idx]) begin
        // Blanked digit keeps its anode on only so the decimal point lights.
        an_d = an_onecold(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      frame_tick <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      if (frame_end) begin
        value_q <= value;
        dp_q    <= dp_in;
      end
      frame_tick <= frame_end;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
    end
  end

endmodule

// File: tb/tb_sseg_display_driver.sv
// tb_sseg_display_driver: directed, table-driven bench for
// sseg_display_driver with DIGIT_PERIOD_CYCLES=8, BLANK_CYCLES=2.
// Honours SSEG_LZ_BLANK_EN when defined for the build.
module tb_sseg_display_driver;

  localparam int P = 8;
  localparam int B = 2;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  sseg_display_driver #(
    .DIGIT_PERIOD_CYCLES (P),
    .BLANK_CYCLES        (B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      value;
    logic [3:0]       dp_in;
    logic [3:0][6:0]  glyph;    // expected seg per digit, [3] = leftmost
    logic [3:0]       lz_mask;  // digits that are leading zeros
  } vec_t;

  localparam logic [15:0] DECOY_VALUE = 16'hFFFF;
  localparam logic [3:0]  DECOY_DP    = 4'hF;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  vec_t zero_rec;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},  32'(an),         32'h0000000F);
    chk({tag, "_seg"}, 32'(seg),        32'h0000007F);
    chk({tag, "_dp"},  32'(dp),         32'h00000001);
    chk({tag, "_ft"},  32'(frame_tick), 32'h00000000);
  endtask

  // Checks one 32-cycle frame that displays r. Cycle j reflects slot
  // counter j%P of digit j/P. Inputs: a decoy mid-frame, the next record
  // just before the latch edge, a decoy again right after it.
  // abort_at >= 0 asserts reset after checking that cycle and returns.
  task automatic check_frame(input vec_t r, input vec_t nxt, input int abort_at);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       lzb;
    int         d;
    int         c;
    for (int j = 0; j < 4 * P; j++) begin
      @(posedge clk);
      #1;
      d = j / P;
      c = j % P;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (c >= B) begin
        lzb = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
        lzb = r.lz_mask[d];
`endif
        e_dp = ~r.dp_in[d];
        if (!lzb) begin
          e_an  = ~(4'b0001 << d);
          e_seg = r.glyph[d];
        end else if (r.dp_in[d]) begin
          e_an = ~(4'b0001 << d);
        end
      end
      chk($sformatf("an_%h_j%0d", r.value, j),  32'(an),  32'(e_an));
      chk($sformatf("seg_%h_j%0d", r.value, j), 32'(seg), 32'(e_seg));
      chk($sformatf("dp_%h_j%0d", r.value, j),  32'(dp),  32'(e_dp));
      chk($sformatf("ft_%h_j%0d", r.value, j),  32'(frame_tick), 32'(j == 4 * P - 1));
      if (j == abort_at) begin
        reset = 1'b1;
        return;
      end
      if (j == P + 4) begin
        value = DECOY_VALUE;
        dp_in = DECOY_DP;
      end else if (j == 4 * P - 2) begin
        value = nxt.value;
        dp_in = nxt.dp_in;
      end else if (j == 4 * P - 1) begin
        value = DECOY_VALUE;
        dp_in = DECOY_DP;
      end
    end
  endtask

  initial begin
    zero_rec = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110};
    vecs[0]  = '{16'h1111, 4'b0000, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b0000};
    vecs[1]  = '{16'hA5C3, 4'b0100, {7'h08, 7'h12, 7'h46, 7'h30}, 4'b0000};
    vecs[2]  = '{16'h0040, 4'b0000, {7'h40, 7'h40, 7'h19, 7'h40}, 4'b1100};
    vecs[3]  = '{16'h0100, 4'b1000, {7'h40, 7'h79, 7'h40, 7'h40}, 4'b1000};
    vecs[4]  = '{16'h8E2F, 4'b1111, {7'h00, 7'h06, 7'h24, 7'h0E}, 4'b0000};
    vecs[5]  = '{16'h0000, 4'b0001, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110};

    reset = 1'b1;
    value = DECOY_VALUE;
    dp_in = DECOY_DP;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset_vals($sformatf("rst%0d", i));
    end
    reset = 1'b0;

    // First frame shows value_q = 0; decoy held in reset must not appear.
    check_frame(zero_rec, vecs[0], -1);
    for (int i = 0; i < 5; i++) begin
      check_frame(vecs[i], vecs[i + 1], -1);
    end

    // Reset during digit 2's active phase aborts the scan.
    check_frame(vecs[5], vecs[0], 2 * P + 4);
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    value = 16'h1111;
    dp_in = 4'b0000;
    reset = 1'b0;
    check_frame(zero_rec, vecs[0], -1);
    check_frame(vecs[0], vecs[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
